collector_arbiter: RTL

- Shares one collector input port among NUM_REQ upstream local-port sources, such as several router local ports or virtual channels ejecting to one PE sink.
- Uses the Req/Gnt/Full handshake the collectors already speak on both sides.
- Round-robin selection with a registered forward path; carries at most one packet at a time.
- Sits between the ejecting sources and the collector.

---
 rtl/collector_arbiter_if.sv | 38 +++
 rtl/collector_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/collector_arbiter_if.sv
// collector_arbiter_if: bundles the upstream (NUM_REQ sources) and downstream
// (one collector) Req/Gnt/Full signals of the collector arbiter.
//
// Handshake: a requester raises Req with its data stable and holds both until
// the matching one-cycle Gnt pulse. Full is advisory backpressure. Req may
// stay high while Full is set. The arbiter speaks the same protocol to the
// collector: ReqDnStr and PacketOut stay stable until GntDnStr is sampled high.
//
// Modports:
//   master - the arbiter's view (drives grants, fulls, PacketOut, ReqDnStr,
//            Busy, Timeout and the state_dbg debug output)
//   slave  - the environment's view (sources plus collector)
interface collector_arbiter_if #(
  parameter int dataWidth = 32,
  parameter int NUM_REQ   = 4
);
  logic [NUM_REQ*dataWidth-1:0] PacketIn;
  logic [NUM_REQ-1:0]           ReqUpStr;
  logic [NUM_REQ-1:0]           GntUpStr;
  logic [NUM_REQ-1:0]           UpStrFull;
  logic [dataWidth-1:0]         PacketOut;
  logic                         ReqDnStr;
  logic                         GntDnStr;
  logic                         DnStrFull;
  logic                         Busy;
  logic                         Timeout;
  logic [1:0]                   state_dbg;

  modport master (
    input  PacketIn, ReqUpStr, GntDnStr, DnStrFull,
    output GntUpStr, UpStrFull, PacketOut, ReqDnStr, Busy, Timeout, state_dbg
  );

  modport slave (
    output PacketIn, ReqUpStr, GntDnStr, DnStrFull,
    input  GntUpStr, UpStrFull, PacketOut, ReqDnStr, Busy, Timeout, state_dbg
  );
endinterface

// File: rtl/collector_arbiter.sv
// collector_arbiter: shares one collector input among NUM_REQ ejecting
// sources. Round-robin pick in IDLE, registered packet forward, one packet in
// flight at a time.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - collector_arbiter_if.master: PacketIn, ReqUpStr, GntUpStr,
//            UpStrFull, PacketOut, ReqDnStr, GntDnStr, DnStrFull, Busy,
//            Timeout, state_dbg (FSM state: 0 IDLE, 1 WAIT_GNT, 2 RELEASE)
//
// Optional feature: define COLLECTOR_ARB_TIMEOUT_EN to abandon a collector
// request after TIMEOUT WAIT_GNT cycles with no grant, setting a sticky
// Timeout flag. Without it Timeout is tied low and WAIT_GNT waits forever.
module collector_arbiter #(
  parameter int dataWidth = 32,
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  collector_arbiter_if.master  bus
);

  if (IDX_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("collector_arbiter: inconsistent parameters");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [dataWidth-1:0]   pkt_q, pkt_d;
  logic                   req_dn_q, req_dn_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     full_q, full_d;
  logic                   busy;

  logic [IDX_W-1:0]       sel;
  logic                   sel_vld;
  logic [dataWidth-1:0]   sel_pkt;

  assign busy = (state_q != IDLE);

  // Round-robin pick: scan offsets NUM_REQ down to 1 so the smallest offset
  // from the last winner (the first requester after it, with wrap) is the
  // final assignment and therefore wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (((int'(last_q) + k) % NUM_REQ) == i && bus.ReqUpStr[i]) begin
          sel     = IDX_W'(i);
          sel_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_W'(i)) sel_pkt = bus.PacketIn[i*dataWidth +: dataWidth];
    end
  end

  // Full for everyone when the collector is full; otherwise full for all but
  // the current winner while a transfer is in flight.
  always_comb begin
    full_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      full_d[i] = bus.DnStrFull | (busy & (win_q != IDX_W'(i)));
    end
  end

`ifdef COLLECTOR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             expire;

  // cnt_q holds (WAIT_GNT cycles already spent); on the TIMEOUT-th cycle it
  // equals TIMEOUT-1, and that is the last cycle a grant is still accepted.
  assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    last_d   = last_q;
    pkt_d    = pkt_q;
    req_dn_d = req_dn_q;
    gnt_d    = '0;
`ifdef COLLECTOR_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    to_d     = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (!bus.DnStrFull && sel_vld) begin
          win_d    = sel;
          pkt_d    = sel_pkt;
          req_dn_d = 1'b1;
          state_d  = WAIT_GNT;
`ifdef COLLECTOR_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      WAIT_GNT: begin
        // A grant on the expiry cycle still wins over the timeout.
        if (bus.GntDnStr) begin
          req_dn_d = 1'b0;
          gnt_d    = NUM_REQ'(1) << win_q;
          last_d   = win_q;
          state_d  = RELEASE;
        end
`ifdef COLLECTOR_ARB_TIMEOUT_EN
        else if (expire) begin
          req_dn_d = 1'b0;
          to_d     = 1'b1;
          last_d   = win_q;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RELEASE: begin
        // The winner's Req is not looked at here; it has this cycle to drop.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      pkt_q    <= '0;
      req_dn_q <= 1'b0;
      gnt_q    <= '0;
      full_q   <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      pkt_q    <= pkt_d;
      req_dn_q <= req_dn_d;
      gnt_q    <= gnt_d;
      full_q   <= full_d;
    end
  end

`ifdef COLLECTOR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign bus.Timeout = to_q;
`else
  assign bus.Timeout = 1'b0;
`endif

  assign bus.GntUpStr  = gnt_q;
  assign bus.UpStrFull = full_q;
  assign bus.PacketOut = pkt_q;
  assign bus.ReqDnStr  = req_dn_q;
  assign bus.Busy      = busy;
  assign bus.state_dbg = state_q;

endmodule
